pipe_if: RTL and testbench

- Instruction-fetch stage of the cpu55 five-stage pipeline; the read-side counterpart of the write-back stage.
- Holds the program counter and issues word reads to the instruction RAM, which is a `ram` instance with 32-bit data, 10-bit address and 1-cycle synchronous read.
- Presents {valid, pc, instruction} to decode.
- Supports decode back-pressure (stall) through a one-entry skid buffer, and redirects (branch/jump) with in-flight kill.

---
 rtl/pipe_if.sv | 85 ++++++++
 tb/tb_pipe_if.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_if.sv
// rtl/pipe_if.sv - instruction-fetch stage: pc, imem read issue, one-entry skid buffer, redirect kill
//
// Ports:
//   clk, resetn          clock and asynchronous active-low reset
//   stall                decode cannot accept the presented instruction this cycle
//   redirect_valid/_pc   branch/jump: restart fetch at redirect_pc (bits [1:0] ignored)
//   imem_rd_en/_addr     word read request to the instruction RAM (1-cycle synchronous read)
//   imem_rdata           RAM data for the request issued on the previous cycle
//   if_valid/_pc/_inst   instruction presented to decode
module pipe_if #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  imem_rd_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  if_valid,
    output logic [31:0]           if_pc,
    output logic [DATA_WIDTH-1:0] if_inst
);

    logic [31:0]           pc;
    logic                  req_valid;
    logic [31:0]           req_pc;
    logic                  hold_valid;
    logic [31:0]           hold_pc;
    logic [DATA_WIDTH-1:0] hold_inst;

    logic [31:0] fetch_pc;
    logic        issue;
    logic        capture;

    assign fetch_pc   = redirect_valid ? (redirect_pc & ~32'h3) : pc;
    // A redirect always issues, even under stall, so the new target is never delayed.
    assign issue      = redirect_valid | ~stall;
    assign imem_rd_en = resetn & issue;
    assign imem_addr  = fetch_pc[ADDR_WIDTH+1:2];

    // The RAM response is only on imem_rdata for one cycle; park it if decode is stalled.
    assign capture = stall & ~redirect_valid & req_valid & ~hold_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc         <= RESET_PC;
            req_valid  <= 1'b0;
            req_pc     <= 32'h0;
            hold_valid <= 1'b0;
            hold_pc    <= 32'h0;
            hold_inst  <= '0;
        end else begin
            if (issue) begin
                req_valid <= 1'b1;
                req_pc    <= fetch_pc;
                pc        <= fetch_pc + 32'd4;
            end else begin
                req_valid <= 1'b0;
            end

            // Release: the held entry is consumed this cycle while the next read is already
            // issued. Redirect: the held entry belongs to the wrong path.
            if (issue) begin
                hold_valid <= 1'b0;
            end else if (capture) begin
                hold_valid <= 1'b1;
                hold_pc    <= req_pc;
                hold_inst  <= imem_rdata;
            end
        end
    end

    // A redirect kills whatever is presented this cycle (the one bubble of redirect penalty).
    assign if_valid = ~redirect_valid & (hold_valid | req_valid);
    assign if_pc    = hold_valid ? hold_pc : req_pc;
    // imem_rdata is outside this block's reset, so force the output quiet while in reset.
    assign if_inst  = !resetn    ? '0
                    : hold_valid ? hold_inst
                    :              imem_rdata;

endmodule

// File: tb/tb_pipe_if.sv
// tb/tb_pipe_if.sv - randomized and directed self-checking bench for pipe_if
module tb_pipe_if;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_rd_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [1024];

    pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    always #5 clk = ~clk;

    // Instruction RAM: 1-cycle synchronous read, data holds when not enabled.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of what decode sees: whether an instruction is presented (m_avail) and
    // the byte address of the next instruction decode should receive (m_pc). The fetch
    // address runs one word ahead of a presented instruction.
    logic        m_avail = 1'b0;
    logic [31:0] m_pc = RESET_PC;

    always @(negedge clk) begin
        logic        exp_rd;
        logic        exp_v;
        logic [31:0] exp_fetch;
        if (!resetn) begin
            chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
            chk("rst_rd_en", {31'b0, imem_rd_en}, 32'h0);
            chk("rst_if_pc", if_pc, 32'h0);
            chk("rst_if_inst", if_inst, 32'h0);
            m_avail = 1'b0;
            m_pc    = RESET_PC;
        end else begin
            exp_rd = redirect_valid | ~stall;
            exp_v  = m_avail & ~redirect_valid;
            chk("m_rd_en", {31'b0, imem_rd_en}, {31'b0, exp_rd});
            chk("m_if_valid", {31'b0, if_valid}, {31'b0, exp_v});
            if (exp_v) begin
                chk("m_if_pc", if_pc, m_pc);
                chk("m_if_inst", if_inst, mem[m_pc[11:2]]);
            end
            if (exp_rd) begin
                exp_fetch = redirect_valid ? redirect_pc : (m_avail ? m_pc + 32'd4 : m_pc);
                chk("m_imem_addr", {22'b0, imem_addr}, {22'b0, exp_fetch[11:2]});
            end
            if (redirect_valid) begin
                m_avail = 1'b1;
                m_pc    = redirect_pc & ~32'h3;
            end else if (!stall) begin
                if (m_avail) m_pc = m_pc + 32'd4;
                m_avail = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] rp);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;

        #3;
        chk("reset_if_valid", {31'b0, if_valid}, 32'h0);
        chk("reset_rd_en", {31'b0, imem_rd_en}, 32'h0);
        step();
        step();
        resetn = 1'b1;
        drive(0, 0, 0);
        chk("first_rd_en", {31'b0, imem_rd_en}, 32'h1);
        chk("first_addr", {22'b0, imem_addr}, 32'h0);
        chk("first_bubble", {31'b0, if_valid}, 32'h0);
        step();
        chk("lat_valid", {31'b0, if_valid}, 32'h1);
        chk("lat_pc", if_pc, 32'h0);
        chk("lat_inst", if_inst, 32'h1000_0000);
        chk("lat_addr", {22'b0, imem_addr}, 32'h1);
        step();
        chk("seq_pc4", if_pc, 32'h4);
        chk("seq_inst4", if_inst, 32'h1000_0001);
        step();
        chk("seq_pc8", if_pc, 32'h8);

        // Stall three cycles on 0x8.
        drive(1, 0, 0);
        chk("stall_rd_en", {31'b0, imem_rd_en}, 32'h0);
        chk("stall_pc", if_pc, 32'h8);
        chk("stall_inst", if_inst, 32'h1000_0002);
        step();
        chk("stall2_valid", {31'b0, if_valid}, 32'h1);
        chk("stall2_pc", if_pc, 32'h8);
        step();
        chk("stall3_pc", if_pc, 32'h8);
        chk("stall3_inst", if_inst, 32'h1000_0002);
        drive(0, 0, 0);
        chk("release_pc", if_pc, 32'h8);
        step();
        chk("after_release_pc", if_pc, 32'hC);
        step();
        chk("after_release_pc2", if_pc, 32'h10);

        // Redirect while streaming.
        drive(0, 1, 32'h43);
        chk("redir_kill", {31'b0, if_valid}, 32'h0);
        chk("redir_addr", {22'b0, imem_addr}, 32'h10);
        step();
        drive(0, 0, 0);
        chk("redir_pc", if_pc, 32'h40);
        chk("redir_inst", if_inst, 32'h1000_0010);
        step();
        chk("redir_pc2", if_pc, 32'h44);
        step();
        chk("pre_hold_pc", if_pc, 32'h48);

        // Redirect while stalled with a held entry.
        drive(1, 0, 0);
        step();
        chk("held_pc", if_pc, 32'h48);
        drive(1, 1, 32'h100);
        chk("sredir_rd_en", {31'b0, imem_rd_en}, 32'h1);
        chk("sredir_addr", {22'b0, imem_addr}, 32'h40);
        chk("sredir_kill", {31'b0, if_valid}, 32'h0);
        step();
        drive(1, 0, 0);
        chk("sredir_valid", {31'b0, if_valid}, 32'h1);
        chk("sredir_pc", if_pc, 32'h100);
        step();
        chk("sredir_hold_pc", if_pc, 32'h100);
        drive(0, 0, 0);
        chk("sredir_rel_pc", if_pc, 32'h100);
        step();
        chk("sredir_next_pc", if_pc, 32'h104);

        // RAM index wrap, pc does not wrap.
        drive(0, 1, 32'hFFC);
        chk("wrap_addr0", {22'b0, imem_addr}, 32'h3FF);
        step();
        drive(0, 0, 0);
        chk("wrap_pc0", if_pc, 32'hFFC);
        chk("wrap_inst0", if_inst, 32'h1000_03FF);
        chk("wrap_addr1", {22'b0, imem_addr}, 32'h0);
        step();
        chk("wrap_pc1", if_pc, 32'h1000);
        chk("wrap_inst1", if_inst, 32'h1000_0000);
        chk("wrap_addr2", {22'b0, imem_addr}, 32'h1);
        step();
        chk("wrap_pc2", if_pc, 32'h1004);
        chk("wrap_inst2", if_inst, 32'h1000_0001);

        // Asynchronous reset mid-stream.
        drive(0, 1, 32'h20);
        step();
        drive(0, 0, 0);
        chk("mid_pc", if_pc, 32'h20);
        #1 resetn = 1'b0;
        #1;
        chk("async_valid", {31'b0, if_valid}, 32'h0);
        chk("async_rd_en", {31'b0, imem_rd_en}, 32'h0);
        step();
        resetn = 1'b1;
        #1;
        chk("rerun_addr", {22'b0, imem_addr}, 32'h0);
        chk("rerun_bubble", {31'b0, if_valid}, 32'h0);
        step();
        chk("rerun_valid", {31'b0, if_valid}, 32'h1);
        chk("rerun_pc", if_pc, RESET_PC);

        // Randomized phase, checked by the negedge model.
        for (int i = 0; i < 4000; i++) begin
            logic        st;
            logic        rv;
            logic [31:0] rp;
            st = ($urandom_range(0, 99) < 35);
            rv = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                1:       rp = $urandom & 32'hFFF;
                default: rp = $urandom;
            endcase
            if ($urandom_range(0, 499) == 0) begin
                resetn = 1'b0;
                step();
                resetn = 1'b1;
            end
            drive(st, rv, rp);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
